gate_truth_checker: RTL and testbench
=====================================

GATE_TRUTH_CHECKER -- requirements
Module: gate_truth_checker

Interface
REQ-001 Parameter: SETTLE, default 2, cycles each input vector is held before the gate output is sampled (legal 1..15).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a sweep; accepted only in IDLE.
REQ-005 op  input  2  expected gate: 00 XOR, 01 XNOR, 10 NAND, 11 NOR; captured at start acceptance.
REQ-006 dut_a  output  1  stimulus bit a to gate under test.
REQ-007 dut_b  output  1  stimulus bit b to gate under test.
REQ-008 dut_y  input  1  output of gate under test.
REQ-009 busy  output  1  high while the sweep is running.
REQ-010 done  output  1  one-cycle pulse at sweep completion.
REQ-011 pass  output  1  captured table equals expected table; updated at done, held until next accepted start.
REQ-012 truth  output  4  captured table; bit i = dut_y sampled for vector i = {a,b}.
REQ-013 err_cnt  output  8  failing-sweep count (see Configuration).

Function
REQ-014 FSM states SHALL be IDLE, RUN, DONE; IDLE->RUN on start, RUN->DONE after 4th sample, DONE->IDLE unconditionally.
REQ-015 Start accepted at edge k: op latched, vector index = 0, {dut_a,dut_b}=00, busy=1, pass=0, truth=0 from edge k.
REQ-016 In RUN each vector SHALL be driven for exactly SETTLE cycles; dut_y sampled into truth[index] at the edge ending that interval, next vector driven from that same edge.
REQ-017 Vector order SHALL be 00, 01, 10, 11 ({dut_a,dut_b}).
REQ-018 4th sample at edge k+4*SETTLE; at that edge state->DONE, busy=0, done=1, pass computed, {dut_a,dut_b}=00.
REQ-019 Expected tables (truth[3:0]): XOR 0110, XNOR 1001, NAND 0111, NOR 0001.
REQ-020 pass=1 iff all 4 sampled bits equal expected table for the latched op.
REQ-021 start asserted in RUN or DONE SHALL be ignored (no restart, no queueing); op changes during RUN SHALL be ignored.
REQ-022 start in the cycle after DONE (IDLE) SHALL be accepted; back-to-back sweeps have one idle gap cycle.
REQ-023 dut_a, dut_b SHALL be registered outputs; no combinational path from dut_y to any output.

Reset
REQ-024 On rst: state IDLE, dut_a=0, dut_b=0, busy=0, done=0, pass=0, truth=0000, err_cnt=0, index and settle counter cleared.
REQ-025 rst during RUN SHALL abort the sweep at that edge with no done pulse; rst dominates start in the same cycle.

Configuration
REQ-026 Macro GATE_CHECK_ERRCNT_EN: when defined, err_cnt increments by 1 at each entry to DONE with pass=0, saturating at 255, cleared only by rst.
REQ-027 When GATE_CHECK_ERRCNT_EN is undefined, err_cnt SHALL be constant 0 and no counter logic SHALL be present; all other behaviour identical.

Verification
REQ-028 SETTLE=2, correct XOR model on dut_y, op=00, start at edge k -> done high after edge k+8, truth=0110, pass=1, busy high edges k..k+7.
REQ-029 SETTLE=2, NOR model on dut_y, op=10 -> truth=0001, pass=0, err_cnt=1 with macro, 0 without.
REQ-030 dut_y stuck at 1, op=11 -> truth=1111, pass=0; with macro, 256 such sweeps leave err_cnt=255.
REQ-031 start re-pulsed 3 cycles into RUN, op toggled -> exactly one done, result for originally latched op.
REQ-032 rst asserted at edge k+3 of a sweep -> after that edge busy=0, dut_a=dut_b=0, truth=0000, no done pulse in following 10 cycles.
REQ-033 SETTLE=1, XNOR model, op=01, start held high continuously -> done every 6 cycles, truth=1001, pass=1 each sweep.

Source files
------------

// File: rtl/gate_truth_checker.sv
// Sweeps the four {a,b} input vectors through an external 2-input gate and compares the captured truth table
// against the selected expected gate. Optional failing-sweep counter enabled by macro GATE_CHECK_ERRCNT_EN.
module gate_truth_checker #(
    parameter int SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] op,
    output logic       dut_a,
    output logic       dut_b,
    input  logic       dut_y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] truth,
    output logic [7:0] err_cnt
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

    logic [1:0]       state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [1:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             a_q, a_d;
    logic             b_q, b_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [3:0]       truth_q, truth_d;

    // Bit i of the table is the gate output for vector i = {a,b}.
    function automatic logic [3:0] expected_table(input logic [1:0] sel);
        case (sel)
            2'b00:   expected_table = 4'b0110;
            2'b01:   expected_table = 4'b1001;
            2'b10:   expected_table = 4'b0111;
            default: expected_table = 4'b0001;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        truth_d = truth_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    op_d    = op;
                    idx_d   = 2'd0;
                    cnt_d   = '0;
                    a_d     = 1'b0;
                    b_d     = 1'b0;
                    busy_d  = 1'b1;
                    pass_d  = 1'b0;
                    truth_d = 4'b0000;
                end
            end
            ST_RUN: begin
                if (cnt_q == CNT_LAST) begin
                    // Sample and advance on the same edge so each vector is held exactly SETTLE cycles.
                    truth_d[idx_q] = dut_y;
                    cnt_d          = '0;
                    if (idx_q == 2'd3) begin
                        state_d = ST_DONE;
                        idx_d   = 2'd0;
                        a_d     = 1'b0;
                        b_d     = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (truth_d == expected_table(op_q));
                    end else begin
                        idx_d      = idx_q + 2'd1;
                        {a_d, b_d} = idx_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= 2'b00;
            idx_q   <= 2'd0;
            cnt_q   <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            truth_q <= 4'b0000;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            truth_q <= truth_d;
        end
    end

`ifdef GATE_CHECK_ERRCNT_EN
    logic [7:0] err_q, err_d;
    logic       fail_entry;

    always_comb begin
        fail_entry = done_d && !pass_d;
        err_d      = err_q;
        if (fail_entry && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 8'd0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_cnt = err_q;
`else
    assign err_cnt = 8'd0;
`endif

    assign dut_a = a_q;
    assign dut_b = b_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign pass  = pass_q;
    assign truth = truth_q;

endmodule

// File: tb/tb_gate_truth_checker.sv
// Bench for gate_truth_checker: two instances (SETTLE=2 and SETTLE=1), each driving a behavioural gate model;
// expected tables are queued at start and compared when done pulses.
module tb_gate_truth_checker;

    localparam int S0 = 2;
    localparam int S1 = 1;
`ifdef GATE_CHECK_ERRCNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start0, start1;
    logic [1:0] op0, op1;
    logic       a0, b0, y0, busy0, done0, pass0;
    logic       a1, b1, y1, busy1, done1, pass1;
    logic [3:0] truth0, truth1;
    logic [7:0] err0, err1;
    int         model0, model1;

    int total = 0;
    int bad   = 0;
    logic [4:0] q0[$];
    logic [4:0] q1[$];
    logic [7:0] exp_err0 = 8'd0;

    always #5 clk = ~clk;

    // sel: 0 XOR, 1 XNOR, 2 NAND, 3 NOR, 4 stuck-at-1, other stuck-at-0
    function automatic logic gate_fn(input int sel, input logic a, input logic b);
        case (sel)
            0:       gate_fn = a ^ b;
            1:       gate_fn = ~(a ^ b);
            2:       gate_fn = ~(a & b);
            3:       gate_fn = ~(a | b);
            4:       gate_fn = 1'b1;
            default: gate_fn = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] model_table(input int sel);
        logic [3:0] t;
        logic [1:0] v;
        for (int i = 0; i < 4; i++) begin
            v    = i[1:0];
            t[i] = gate_fn(sel, v[1], v[0]);
        end
        return t;
    endfunction

    function automatic logic [3:0] exp_table(input logic [1:0] sel);
        case (sel)
            2'b00:   exp_table = 4'b0110;
            2'b01:   exp_table = 4'b1001;
            2'b10:   exp_table = 4'b0111;
            default: exp_table = 4'b0001;
        endcase
    endfunction

    assign y0 = gate_fn(model0, a0, b0);
    assign y1 = gate_fn(model1, a1, b1);

    gate_truth_checker #(.SETTLE(S0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .op(op0),
        .dut_a(a0), .dut_b(b0), .dut_y(y0),
        .busy(busy0), .done(done0), .pass(pass0), .truth(truth0), .err_cnt(err0)
    );

    gate_truth_checker #(.SETTLE(S1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .op(op1),
        .dut_a(a1), .dut_b(b1), .dut_y(y1),
        .busy(busy1), .done(done1), .pass(pass1), .truth(truth1), .err_cnt(err1)
    );

    task automatic test_reset();
        rst = 1'b1; start0 = 1'b1; start1 = 1'b1; op0 = 2'b00; op1 = 2'b00;
        @(negedge clk);
        @(negedge clk);
        start0 = 1'b0; start1 = 1'b0;
        total++; if (busy0 !== 1'b0 || busy1 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b%b want=00", busy0, busy1); end
        total++; if (done0 !== 1'b0 || done1 !== 1'b0) begin bad++; $display("FAIL reset_done got=%b%b want=00", done0, done1); end
        total++; if (pass0 !== 1'b0 || pass1 !== 1'b0) begin bad++; $display("FAIL reset_pass got=%b%b want=00", pass0, pass1); end
        total++; if ({a0, b0, a1, b1} !== 4'b0000) begin bad++; $display("FAIL reset_vec got=%b want=0000", {a0, b0, a1, b1}); end
        total++; if (truth0 !== 4'b0000 || truth1 !== 4'b0000) begin bad++; $display("FAIL reset_truth got=%b/%b want=0000", truth0, truth1); end
        total++; if (err0 !== 8'd0 || err1 !== 8'd0) begin bad++; $display("FAIL reset_err got=%0d/%0d want=0", err0, err1); end
        rst = 1'b0;
        exp_err0 = 8'd0;
        @(negedge clk);
        total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL reset_start_dominated got=%b want=0", busy0); end
    endtask

    // One full sweep on instance 0, checking busy and the vector sequence every cycle.
    task automatic run_sweep0(input logic [1:0] op, input int sel);
        logic [3:0] et;
        logic       ep;
        logic [4:0] e;
        logic [1:0] ev;
        int         j;
        et = model_table(sel);
        ep = (et == exp_table(op));
        q0.push_back({et, ep});
        if (!ep && exp_err0 != 8'hFF) exp_err0++;
        model0 = sel; op0 = op; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        j = 0;
        while (done0 !== 1'b1 && j < 4 * S0 + 4) begin
            if (j < 4 * S0) begin
                ev = 2'(j / S0);
                total++; if (busy0 !== 1'b1) begin bad++; $display("FAIL sweep_busy c=%0d got=%b want=1", j, busy0); end
                total++; if ({a0, b0} !== ev) begin bad++; $display("FAIL sweep_vec c=%0d got=%b want=%b", j, {a0, b0}, ev); end
            end
            j++;
            @(negedge clk);
        end
        total++;
        if (done0 !== 1'b1) begin
            bad++; $display("FAIL sweep_timeout got=no_done want=done op=%b", op);
        end else begin
            total++; if (j != 4 * S0) begin bad++; $display("FAIL sweep_latency got=%0d want=%0d", j, 4 * S0); end
            total++; if (busy0 !== 1'b0 || {a0, b0} !== 2'b00) begin bad++; $display("FAIL sweep_end_state got busy=%b vec=%b want 0/00", busy0, {a0, b0}); end
            total++;
            if (q0.size() == 0) begin
                bad++; $display("FAIL sweep_queue got=empty want=entry");
            end else begin
                e = q0.pop_front();
                if (truth0 !== e[4:1]) begin bad++; $display("FAIL sweep_truth op=%b got=%b want=%b", op, truth0, e[4:1]); end
                total++; if (pass0 !== e[0]) begin bad++; $display("FAIL sweep_pass op=%b got=%b want=%b", op, pass0, e[0]); end
            end
            total++; if (err0 !== (ERR_EN ? exp_err0 : 8'd0)) begin bad++; $display("FAIL sweep_err got=%0d want=%0d", err0, (ERR_EN ? exp_err0 : 8'd0)); end
        end
        @(negedge clk);
        total++; if (done0 !== 1'b0) begin bad++; $display("FAIL done_pulse_width got=%b want=0", done0); end
    endtask

    task automatic test_xor();
        run_sweep0(2'b00, 0);
    endtask

    task automatic test_ops();
        run_sweep0(2'b01, 1);
        run_sweep0(2'b10, 2);
        run_sweep0(2'b11, 3);
    endtask

    task automatic test_nor_mismatch();
        run_sweep0(2'b10, 3);
    endtask

    task automatic test_stuck();
        for (int n = 0; n < 256; n++) run_sweep0(2'b11, 4);
        total++; if (err0 !== (ERR_EN ? 8'd255 : 8'd0)) begin bad++; $display("FAIL stuck_err_sat got=%0d want=%0d", err0, (ERR_EN ? 255 : 0)); end
    endtask

    task automatic test_restart();
        logic [4:0] e;
        int         nd;
        nd = 0;
        model0 = 0; op0 = 2'b00; start0 = 1'b1;
        q0.push_back({model_table(0), 1'b1});
        @(negedge clk);
        start0 = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (c == 3) begin start0 = 1'b1; op0 = 2'b11; end
            if (c == 4) start0 = 1'b0;
            if (done0 === 1'b1) begin
                nd++;
                total++;
                if (q0.size() == 0) begin
                    bad++; $display("FAIL restart_queue got=empty want=entry");
                end else begin
                    e = q0.pop_front();
                    if (truth0 !== e[4:1] || pass0 !== e[0]) begin
                        bad++; $display("FAIL restart_result got=%b/%b want=%b/%b", truth0, pass0, e[4:1], e[0]);
                    end
                end
            end
            @(negedge clk);
        end
        total++; if (nd != 1) begin bad++; $display("FAIL restart_done_count got=%0d want=1", nd); end
    endtask

    task automatic test_reset_abort();
        model0 = 4; op0 = 2'b00; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++; if (truth0 !== 4'b0001) begin bad++; $display("FAIL abort_pre_truth got=%b want=0001", truth0); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_err0 = 8'd0;
        total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy0); end
        total++; if ({a0, b0} !== 2'b00) begin bad++; $display("FAIL abort_vec got=%b want=00", {a0, b0}); end
        total++; if (truth0 !== 4'b0000) begin bad++; $display("FAIL abort_truth got=%b want=0000", truth0); end
        total++; if (err0 !== 8'd0) begin bad++; $display("FAIL abort_err got=%0d want=0", err0); end
        for (int c = 0; c < 10; c++) begin
            total++; if (done0 !== 1'b0) begin bad++; $display("FAIL abort_done c=%0d got=%b want=0", c, done0); end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] e;
        int         nd;
        nd = 0;
        model1 = 1; op1 = 2'b01;
        for (int n = 0; n < 3; n++) q1.push_back({model_table(1), 1'b1});
        start1 = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 30 && nd < 3; c++) begin
            if (done1 === 1'b1) begin
                total++; if (c != 4 + 6 * nd) begin bad++; $display("FAIL b2b_period sweep=%0d got=%0d want=%0d", nd, c, 4 + 6 * nd); end
                total++;
                if (q1.size() == 0) begin
                    bad++; $display("FAIL b2b_queue got=empty want=entry");
                end else begin
                    e = q1.pop_front();
                    if (truth1 !== e[4:1] || pass1 !== e[0]) begin
                        bad++; $display("FAIL b2b_result sweep=%0d got=%b/%b want=%b/%b", nd, truth1, pass1, e[4:1], e[0]);
                    end
                end
                nd++;
                if (nd == 3) start1 = 1'b0;
            end
            @(negedge clk);
        end
        start1 = 1'b0;
        total++; if (nd != 3) begin bad++; $display("FAIL b2b_done_count got=%0d want=3", nd); end
        total++; if (err1 !== 8'd0) begin bad++; $display("FAIL b2b_err got=%0d want=0", err1); end
        for (int c = 0; c < 4; c++) @(negedge clk);
        total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%b want=0", busy1); end
    endtask

    initial begin
        model0 = 0; model1 = 0;
        start0 = 1'b0; start1 = 1'b0; op0 = 2'b00; op1 = 2'b00; rst = 1'b1;
        @(negedge clk);
        test_reset();
        test_xor();
        test_ops();
        test_nor_mismatch();
        test_restart();
        test_stuck();
        test_reset_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
